// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use bubble, wrong-path squash after taken branches, memory-wait freeze.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_unit #(
   parameter int REG_W     = 5,
   parameter int FLUSH_LEN = 1
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [REG_W-1:0] IFID_regRs,
   input  logic [REG_W-1:0] IFID_regRt,
   input  logic             IFID_useRt,
   input  logic [REG_W-1:0] IDEX_regRt,
   input  logic             IDEX_memRead,
   input  logic             branch_taken,
   input  logic             mem_wait,
   output logic             pc_write,
   output logic             IFID_write,
   output logic             IDEX_write,
   output logic             EXMEM_write,
   output logic             IFID_flush,
   output logic             IDEX_bubble,
   output logic [15:0]      stall_cnt,
   output logic [15:0]      flush_cnt
);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_LEN - 1);

   state_t     state;
   logic [2:0] fcnt;
   logic       lu;
   logic       stall_case;

   assign lu = IDEX_memRead && (IDEX_regRt != '0) &&
               ((IDEX_regRt == IFID_regRs) || (IFID_useRt && (IDEX_regRt == IFID_regRt)));

   always_comb begin
      // NOTE: every output gets a default first, so no branch below can infer a latch.
      pc_write    = 1'b1;
      IFID_write  = 1'b1;
      IDEX_write  = 1'b1;
      EXMEM_write = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_bubble = 1'b0;
      stall_case  = 1'b0;
      if (arst) begin
         pc_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_write  = 1'b0;
         EXMEM_write = 1'b0;
         IFID_flush  = 1'b1;
         IDEX_bubble = 1'b1;
      end else if (mem_wait) begin
         pc_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_write  = 1'b0;
         EXMEM_write = 1'b0;
      end else if (branch_taken) begin
         IFID_flush  = 1'b1;
         IDEX_bubble = 1'b1;
      end else if (state == FLUSH) begin
         IFID_flush  = 1'b1;
      end else if (lu) begin
         pc_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_bubble = 1'b1;
         stall_case  = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= RUN;
         fcnt  <= '0;
      end else if (mem_wait) begin
         state <= state;
         fcnt  <= fcnt;
      end else if (branch_taken) begin
         if (FLUSH_LEN > 1) begin
            state <= FLUSH;
            fcnt  <= FLUSH_INIT;
         end else begin
            state <= RUN;
            fcnt  <= '0;
         end
      end else if (state == FLUSH) begin
         // Guarding fcnt<=1 keeps the counter from wrapping below zero.
         if (fcnt <= 3'd1) begin
            state <= RUN;
            fcnt  <= '0;
         end else begin
            fcnt  <= fcnt - 3'd1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_q;
   logic [15:0] flush_q;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_case && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
         if (IFID_flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   logic unused_stall;
   assign unused_stall = stall_case;
   assign stall_cnt    = '0;
   assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (FLUSH_LEN=3): expected control vectors and counter
// values are queued when each step is driven and popped when the outputs are sampled.
module tb_hazard_stall_unit;

   localparam int REG_W  = 5;
   localparam int FL_LEN = 3;

`ifdef HAZARD_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   // {pc_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_bubble}
   localparam logic [5:0] P_RUN   = 6'b111100;
   localparam logic [5:0] P_STALL = 6'b001101;
   localparam logic [5:0] P_BR    = 6'b111111;
   localparam logic [5:0] P_FL    = 6'b111110;
   localparam logic [5:0] P_MW    = 6'b000000;
   localparam logic [5:0] P_RST   = 6'b000011;

   typedef struct packed {
      logic [5:0]  ctl;
      logic [15:0] stall;
      logic [15:0] flush;
   } obs_t;

   logic             clk;
   logic             arst;
   logic [REG_W-1:0] IFID_regRs;
   logic [REG_W-1:0] IFID_regRt;
   logic             IFID_useRt;
   logic [REG_W-1:0] IDEX_regRt;
   logic             IDEX_memRead;
   logic             branch_taken;
   logic             mem_wait;
   logic             pc_write;
   logic             IFID_write;
   logic             IDEX_write;
   logic             EXMEM_write;
   logic             IFID_flush;
   logic             IDEX_bubble;
   logic [15:0]      stall_cnt;
   logic [15:0]      flush_cnt;

   obs_t sb[$];
   int   checks;
   int   errors;
   int   exp_stall;
   int   exp_flush;

   hazard_stall_unit #(.REG_W(REG_W), .FLUSH_LEN(FL_LEN)) dut (
      .clk          (clk),
      .arst         (arst),
      .IFID_regRs   (IFID_regRs),
      .IFID_regRt   (IFID_regRt),
      .IFID_useRt   (IFID_useRt),
      .IDEX_regRt   (IDEX_regRt),
      .IDEX_memRead (IDEX_memRead),
      .branch_taken (branch_taken),
      .mem_wait     (mem_wait),
      .pc_write     (pc_write),
      .IFID_write   (IFID_write),
      .IDEX_write   (IDEX_write),
      .EXMEM_write  (EXMEM_write),
      .IFID_flush   (IFID_flush),
      .IDEX_bubble  (IDEX_bubble),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input obs_t obs, input obs_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                tag, obs.ctl, obs.stall, obs.flush, exp.ctl, exp.stall, exp.flush);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, queue its expectation, then sample mid-cycle.
   task automatic step(input string tag, input logic [5:0] pat, input logic rst_v,
                       input logic mw, input logic br, input logic rd,
                       input logic [REG_W-1:0] ex_rt, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt, input logic use_rt);
      obs_t exp;
      obs_t obs;
      @(negedge clk);
      arst         = rst_v;
      mem_wait     = mw;
      branch_taken = br;
      IDEX_memRead = rd;
      IDEX_regRt   = ex_rt;
      IFID_regRs   = rs;
      IFID_regRt   = rt;
      IFID_useRt   = use_rt;
      if (rst_v) begin
         exp_stall = 0;
         exp_flush = 0;
      end
      exp.ctl   = pat;
      exp.stall = STATS_EN ? 16'(exp_stall) : 16'd0;
      exp.flush = STATS_EN ? 16'(exp_flush) : 16'd0;
      sb.push_back(exp);
      #1;
      obs = '{ctl: {pc_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_bubble},
              stall: stall_cnt, flush: flush_cnt};
      check(tag, obs, sb.pop_front());
      if (!rst_v) begin
         if (pat == P_STALL) exp_stall++;
         if (pat[1]) exp_flush++;
      end
   endtask

   task automatic idle(input string tag, input logic [5:0] pat);
      step(tag, pat, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      exp_stall    = 0;
      exp_flush    = 0;
      arst         = 1'b1;
      mem_wait     = 1'b0;
      branch_taken = 1'b0;
      IDEX_memRead = 1'b0;
      IDEX_regRt   = '0;
      IFID_regRs   = '0;
      IFID_regRt   = '0;
      IFID_useRt   = 1'b0;

      step("reset0", P_RST, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      step("reset1", P_RST, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
      idle("run_after_reset", P_RUN);

      // Load-use on rs: exactly one bubble, then free-running.
      step("lu_rs", P_STALL, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0);
      idle("lu_rs_next", P_RUN);
      // Register 0 and unused rt never stall; used rt does.
      step("lu_r0", P_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
      step("lu_rt_unused", P_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
      step("lu_rt_used", P_STALL, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
      step("no_load", P_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1);

      // Taken branch: three flush cycles, bubble only in the first.
      step("br", P_BR, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("br_fl1", P_FL);
      idle("br_fl2", P_FL);
      idle("br_done", P_RUN);

      // Branch with simultaneous load-use; lu stays suppressed during the flush.
      step("br_lu", P_BR, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
      step("br_lu_fl1", P_FL, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
      step("br_lu_fl2", P_FL, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
      idle("br_lu_done", P_RUN);

      // Memory wait in the middle of a flush freezes it; the remainder resumes afterwards.
      step("mw_br", P_BR, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("mw_fl1", P_FL);
      for (int i = 0; i < 4; i++)
         step("mw_hold", P_MW, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0);
      idle("mw_fl2", P_FL);
      idle("mw_done", P_RUN);

      // Memory wait overrides branch and lu in RUN.
      step("mw_over_br", P_MW, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0);
      idle("mw_over_br_after", P_RUN);

      // A branch during FLUSH restarts the count.
      step("rb_br1", P_BR, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("rb_fl1", P_FL);
      step("rb_br2", P_BR, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("rb_fl2", P_FL);
      idle("rb_fl3", P_FL);
      idle("rb_done", P_RUN);

      // Reset in the middle of a flush: immediate forced outputs, no residual flush after.
      step("rst_br", P_BR, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("rst_fl1", P_FL);
      step("rst_mid", P_RST, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("rst_release", P_RUN);
      idle("rst_run", P_RUN);
      step("rst_lu", P_STALL, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
      idle("rst_end", P_RUN);

      checks++;
      assert (sb.size() === 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d entries, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
